// File: rtl/fb_plot.sv
// Pixel plotter: queues draw-unit pixels in a small FIFO and writes them to a framebuffer.
// Optional build macro FB_PLOT_CLIP_EN drops pixels outside CLIP_XMAX/CLIP_YMAX.
module fb_plot #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] CLIP_XMAX = 8'd159,
  parameter logic [7:0] CLIP_YMAX = 8'd119
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        EN,
  input  logic [7:0]  X_In,
  input  logic [7:0]  Y_In,
  input  logic [2:0]  COLOR,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  input  logic        FINISH,
  output logic [15:0] FB_ADDR,
  output logic [2:0]  FB_DATA,
  output logic        FB_WE,
  input  logic        FB_READY,
  output logic        DONE,
  output logic [15:0] PIX_CNT
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t        state_q;
  logic [18:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   pix_cnt_q;
  logic [18:0]   head;
  logic          in_range, accept, push, pop, not_empty;

`ifdef FB_PLOT_CLIP_EN
  assign in_range = (X_In <= CLIP_XMAX) && (Y_In <= CLIP_YMAX);
`else
  logic unused_clip;
  assign unused_clip = ^{CLIP_XMAX, CLIP_YMAX};
  assign in_range    = 1'b1;
`endif

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign not_empty = (cnt_q != '0);
  assign PIX_READY = !ARESET && (state_q == ST_RUN) && (cnt_q != FULL_CNT);
  assign accept    = PIX_VALID && PIX_READY;
  assign push      = accept && in_range;
  assign FB_WE     = !ARESET && not_empty;
  assign pop       = FB_WE && FB_READY;
  assign head      = mem_q[rd_ptr_q];
  assign FB_ADDR   = FB_WE ? head[18:3] : 16'h0000;
  assign FB_DATA   = FB_WE ? head[2:0]  : 3'b000;
  assign DONE      = !ARESET && (state_q == ST_DONE);
  assign PIX_CNT   = pix_cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= {Y_In, X_In, COLOR};
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pix_cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);

      if (state_q == ST_IDLE && EN)
        pix_cnt_q <= 16'h0000;
      else if (pop && pix_cnt_q != 16'hFFFF)
        pix_cnt_q <= pix_cnt_q + 16'd1;

      case (state_q)
        ST_IDLE:  if (EN) state_q <= ST_RUN;
        ST_RUN:   if (FINISH) state_q <= ST_DRAIN;
        ST_DRAIN: if (!not_empty) state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_plot.sv
// Bench for fb_plot: directed job scenarios plus random jobs, checked every cycle
// against a queue-based model of the pixel stream and job phases.
module tb_fb_plot;
  localparam int DEPTH = 8;

  logic        ACLK = 1'b0;
  logic        ARESET, EN, PIX_VALID, FINISH, FB_READY;
  logic [7:0]  X_In, Y_In;
  logic [2:0]  COLOR;
  logic        PIX_READY, FB_WE, DONE;
  logic [15:0] FB_ADDR, PIX_CNT;
  logic [2:0]  FB_DATA;

  fb_plot #(.DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .EN(EN), .X_In(X_In), .Y_In(Y_In),
    .COLOR(COLOR), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .FINISH(FINISH), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WE(FB_WE),
    .FB_READY(FB_READY), .DONE(DONE), .PIX_CNT(PIX_CNT)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  // Reference model: pending pixels as {Y,X,COLOR}, job phase 0=idle 1=run 2=drain 3=done
  logic [18:0] mq[$];
  int          mphase = 0;
  logic [15:0] mcnt = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_window(input logic [7:0] x, input logic [7:0] y);
`ifdef FB_PLOT_CLIP_EN
    return (x <= 8'd159) && (y <= 8'd119);
`else
    return 1'b1;
`endif
  endfunction

  task automatic cycle(input bit arst, input bit en, input bit valid,
                       input logic [7:0] x, input logic [7:0] y, input logic [2:0] c,
                       input bit fin, input bit rdy, output bit acc);
    bit exp_ready, exp_we;
    int pre_size;
    ARESET = arst; EN = en; PIX_VALID = valid; X_In = x; Y_In = y;
    COLOR = c; FINISH = fin; FB_READY = rdy;
    @(negedge ACLK);
    pre_size  = mq.size();
    exp_ready = !arst && (mphase == 1) && (pre_size < DEPTH);
    exp_we    = !arst && (pre_size > 0);
    check("pix_ready", PIX_READY, exp_ready);
    check("fb_we", FB_WE, exp_we);
    check("done", DONE, !arst && (mphase == 3));
    check("pix_cnt", PIX_CNT, mcnt);
    if (exp_we) begin
      check("fb_addr", FB_ADDR, mq[0][18:3]);
      check("fb_data", FB_DATA, mq[0][2:0]);
    end else if (arst) begin
      check("rst_addr", FB_ADDR, 0);
      check("rst_data", FB_DATA, 0);
    end
    if (DONE === 1'b1) done_seen++;
    acc = exp_ready && valid;
    if (arst) begin
      mq.delete();
      mphase = 0;
      mcnt = 16'h0000;
    end else begin
      if (exp_we && rdy) begin
        void'(mq.pop_front());
        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
      if (acc && in_window(x, y)) mq.push_back({y, x, c});
      case (mphase)
        0: if (en) begin mphase = 1; mcnt = 16'h0000; end
        1: if (fin) mphase = 2;
        2: if (pre_size == 0) mphase = 3;
        default: mphase = 0;
      endcase
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 8'h00, 3'd0, 0, rdy, a);
  endtask

  task automatic start_job();
    bit a;
    done_seen = 0;
    cycle(0, 1, 0, 8'h00, 8'h00, 3'd0, 0, 1, a);
  endtask

  // Offer one pixel until it is accepted, bounded; returns cycles spent stalled.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c,
                      input bit fin, input bit rdy, output int stalls);
    bit a;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, 1, x, y, c, fin, rdy, a);
      if (a) break;
      stalls++;
    end
    check("send_bound", (stalls < 100), 1);
  endtask

  task automatic finish_and_drain(input bit rand_rdy);
    bit a;
    cycle(0, 0, 0, 8'h00, 8'h00, 3'd0, 1, 1, a);
    for (int i = 0; i < 400 && mphase != 0; i++)
      cycle(0, 0, 0, 8'h00, 8'h00, 3'd0, 0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, a);
    check("job_done_once", done_seen, 1);
  endtask

  initial begin
    bit a;
    int st, acc_n, tot;
    logic [7:0] rx, ry;

    // Reset
    cycle(1, 0, 1, 8'h11, 8'h22, 3'd5, 0, 1, a);
    cycle(1, 1, 1, 8'h11, 8'h22, 3'd5, 1, 1, a);
    idle(2, 1);

    // Basic job
    start_job();
    for (int i = 0; i < 3; i++) send(8'(i), 8'(i), 3'(i + 1), 0, 1, st);
    finish_and_drain(0);
    check("basic_pix_cnt", PIX_CNT, 16'd3);
    idle(2, 1);
    check("cnt_held_after_done", PIX_CNT, 16'd3);

    // Backpressure: 9 offered while framebuffer stalls
    start_job();
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 8'(acc_n), 8'(acc_n + 16), 3'(acc_n), 0, 0, a);
      if (a) acc_n++;
    end
    check("bp_ready_low", PIX_READY, 0);
    check("bp_head_hold", FB_ADDR, 16'h1000);
    send(8'(8), 8'(24), 3'(0), 0, 1, st);
    finish_and_drain(0);
    check("bp_pix_cnt", PIX_CNT, 16'd9);

    // Wrap and simultaneous push/pop at full rate
    start_job();
    tot = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'(i * 3), 8'(i), 3'(i), 0, 1, st);
      tot += st;
    end
    check("wrap_no_stall", tot, 0);
    finish_and_drain(0);
    check("wrap_pix_cnt", PIX_CNT, 16'd20);

    // FINISH on the same edge as the 5th accepted pixel
    start_job();
    for (int i = 0; i < 4; i++) send(8'(i + 40), 8'(i + 50), 3'd6, 0, 1, st);
    send(8'd99, 8'd77, 3'd2, 1, 1, st);
    for (int i = 0; i < 50 && mphase != 0; i++) idle(1, 1);
    check("fin_same_done", done_seen, 1);
    check("fin_same_cnt", PIX_CNT, 16'd5);

    // Reset with pixels queued
    start_job();
    for (int i = 0; i < 4; i++) send(8'(i + 5), 8'(i + 6), 3'd1, 0, 0, st);
    cycle(1, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, a);
    check("rst_mid_we", FB_WE, 0);
    check("rst_mid_cnt", PIX_CNT, 0);
    idle(3, 1);
    check("rst_mid_idle_ready", PIX_READY, 0);

    // Clip window
    start_job();
    send(8'd200, 8'd10, 3'd3, 0, 1, st);
    send(8'd10, 8'd10, 3'd4, 0, 1, st);
    finish_and_drain(0);
`ifdef FB_PLOT_CLIP_EN
    check("clip_pix_cnt", PIX_CNT, 16'd1);
`else
    check("noclip_pix_cnt", PIX_CNT, 16'd2);
`endif

    // Random jobs with random backpressure, stray EN and coordinates
    for (int j = 0; j < 8; j++) begin
      start_job();
      for (int i = 0; i < $urandom_range(5, 40); i++) begin
        rx = 8'($urandom);
        ry = 8'($urandom);
        cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rx, ry,
              3'($urandom), 0, 1'($urandom_range(0, 1)), a);
      end
      finish_and_drain(1);
      idle($urandom_range(0, 3), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
